m8_frame_checker: RTL

//  Receive-side checker for the 1024-word, 12-bit M8 telemetry frame built by the imitator's filler stage.

---
 rtl/m8_frame_checker_if.sv | 23 ++
 rtl/m8_frame_checker.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/m8_frame_checker_if.sv
// Word stream into the M8 frame checker and the status it reports back.
interface m8_frame_checker_if;
   logic        word_valid;
   logic        frame_start;
   logic [11:0] data_word;
   logic        clr_err;
   logic        locked;
   logic        frame_done;
   logic [9:0]  frame_cnt;
   logic [9:0]  slow_val;
   logic [4:0]  err_flags;
   logic [15:0] err_count;

   modport master (
      output word_valid, frame_start, data_word, clr_err,
      input  locked, frame_done, frame_cnt, slow_val, err_flags, err_count
   );

   modport slave (
      input  word_valid, frame_start, data_word, clr_err,
      output locked, frame_done, frame_cnt, slow_val, err_flags, err_count
   );
endinterface

// File: rtl/m8_frame_checker.sv
// Receive-side checker for the 1024-word M8 telemetry frame: tracks word position,
// checks frame/data/slow counters and filler, and reports lock and error status.
//
// state | meaning
// HUNT  | waiting for a frame_start word; all other words discarded
// FIRST | first frame after sync; checked, must be error-free to lock
// LOCK  | synchronised; full checking, drops after repeated frame counter errors
module m8_frame_checker #(
   parameter int          FRAME_LEN   = 1024,
   parameter int          SLOW_IDX    = 297,
   parameter int          DAT_OFS     = 2,
   parameter logic [11:0] FILL_WORD   = 12'h002,
   parameter int          LOSS_FRAMES = 2
) (
   input  logic              clk,
   input  logic              reset,
   m8_frame_checker_if.slave bus
);

   localparam int IW = $clog2(FRAME_LEN);
   localparam int LW = $clog2(LOSS_FRAMES + 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);
   localparam logic [IW-1:0] SLOW_POS = IW'(SLOW_IDX);
   localparam logic [4:0]    DAT_POS  = 5'(DAT_OFS);

   typedef enum logic [1:0] {HUNT, FIRST, LOCK} state_t;

   state_t        state, state_n;
   logic [IW-1:0] idx, idx_n;
   logic [9:0]    frame_cnt_r, frame_cnt_n;
   logic [9:0]    slow_r, slow_n;
   logic [7:0]    data_ref, data_ref_n;
   logic          slow_vld, slow_vld_n;
   logic          data_vld, data_vld_n;
   logic [4:0]    flags_r, flags_n;
   logic [15:0]   count_r, count_n;
   logic          done_r, done_n;
   logic          frame_bad, frame_bad_n;
   logic [LW-1:0] loss, loss_n, loss_inc;

   logic [9:0]    fld;
   logic [4:0]    chk;
   logic [4:0]    err_hit;
   logic          count_inc;

   assign fld      = bus.data_word[10:1];
   assign loss_inc = loss + 1'b1;

   // Per-word layout checks at the current position.
   always_comb begin
      chk = '0;
      if (idx == '0) begin
         chk[0] = bus.data_word[11] | ~bus.data_word[0];
         chk[1] = (state == LOCK) && (fld != frame_cnt_r - 10'd1);
      end else if (idx == SLOW_POS) begin
         chk[0] = bus.data_word[11] | bus.data_word[0];
         chk[3] = slow_vld && (fld != slow_r) && (fld != slow_r + 10'd1);
      end else if (idx[4:0] == DAT_POS) begin
         chk[0] = bus.data_word[11] | (bus.data_word[2:0] != 3'b001);
         chk[2] = data_vld && (bus.data_word[10:3] != data_ref + 8'd1);
      end else begin
         chk[4] = (bus.data_word != FILL_WORD);
      end
   end

   always_comb begin
      state_n     = state;
      idx_n       = idx;
      frame_cnt_n = frame_cnt_r;
      slow_n      = slow_r;
      data_ref_n  = data_ref;
      slow_vld_n  = slow_vld;
      data_vld_n  = data_vld;
      frame_bad_n = frame_bad;
      loss_n      = loss;
      done_n      = 1'b0;
      err_hit     = '0;
      count_inc   = 1'b0;

      if (bus.word_valid) begin
         unique case (state)
            HUNT: begin
               if (bus.frame_start) begin
                  state_n     = FIRST;
                  idx_n       = IW'(1);
                  frame_cnt_n = fld;
                  frame_bad_n = 1'b0;
                  loss_n      = '0;
               end
            end
            FIRST, LOCK: begin
               if (bus.frame_start && idx != '0) begin
                  // The restart word opens a fresh FIRST frame; its framing error is not held against it.
                  err_hit[0]  = 1'b1;
                  count_inc   = 1'b1;
                  frame_cnt_n = fld;
                  idx_n       = IW'(1);
                  state_n     = FIRST;
                  frame_bad_n = 1'b0;
                  loss_n      = '0;
               end else if (idx == '0 && !bus.frame_start) begin
                  err_hit[0]  = 1'b1;
                  count_inc   = 1'b1;
                  state_n     = HUNT;
                  slow_vld_n  = 1'b0;
                  data_vld_n  = 1'b0;
               end else begin
                  err_hit     = chk;
                  count_inc   = |chk;
                  frame_bad_n = (idx == '0) ? (|chk) : (frame_bad | (|chk));

                  if (idx == '0) begin
                     frame_cnt_n = fld;
                  end else if (idx == SLOW_POS) begin
                     slow_n     = fld;
                     slow_vld_n = 1'b1;
                  end else if (idx[4:0] == DAT_POS) begin
                     data_ref_n = bus.data_word[10:3];
                     data_vld_n = 1'b1;
                  end

                  if (idx == LAST_IDX) begin
                     done_n = 1'b1;
                     idx_n  = '0;
                     if (state == FIRST) begin
                        if (frame_bad_n) begin
                           state_n    = HUNT;
                           slow_vld_n = 1'b0;
                           data_vld_n = 1'b0;
                        end else begin
                           state_n = LOCK;
                        end
                     end
                  end else begin
                     idx_n = idx + 1'b1;
                  end

                  if (idx == '0 && state == LOCK) begin
                     if (chk[1]) begin
                        if (loss_inc >= LW'(LOSS_FRAMES)) begin
                           state_n    = HUNT;
                           idx_n      = '0;
                           slow_vld_n = 1'b0;
                           data_vld_n = 1'b0;
                           loss_n     = '0;
                        end else begin
                           loss_n = loss_inc;
                        end
                     end else begin
                        loss_n = '0;
                     end
                  end
               end
            end
            default: state_n = HUNT;
         endcase
      end

      if (bus.clr_err) begin
         flags_n = '0;
         count_n = '0;
      end else begin
         flags_n = flags_r | err_hit;
         count_n = (count_inc && count_r != 16'hFFFF) ? count_r + 16'd1 : count_r;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= HUNT;
         idx         <= '0;
         frame_cnt_r <= '0;
         slow_r      <= '0;
         data_ref    <= '0;
         slow_vld    <= 1'b0;
         data_vld    <= 1'b0;
         flags_r     <= '0;
         count_r     <= '0;
         done_r      <= 1'b0;
         frame_bad   <= 1'b0;
         loss        <= '0;
      end else begin
         state       <= state_n;
         idx         <= idx_n;
         frame_cnt_r <= frame_cnt_n;
         slow_r      <= slow_n;
         data_ref    <= data_ref_n;
         slow_vld    <= slow_vld_n;
         data_vld    <= data_vld_n;
         flags_r     <= flags_n;
         count_r     <= count_n;
         done_r      <= done_n;
         frame_bad   <= frame_bad_n;
         loss        <= loss_n;
      end
   end

   assign bus.locked     = (state == LOCK);
   assign bus.frame_done = done_r;
   assign bus.frame_cnt  = frame_cnt_r;
   assign bus.slow_val   = slow_r;
   assign bus.err_flags  = flags_r;
   assign bus.err_count  = count_r;

endmodule
